// File: rtl/ifetch_unit_if.sv
// ifetch_unit_if: decode-side valid/ready handshake carrying the fetched word and its PC.
interface ifetch_unit_if;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready;
    modport master (output if_valid, if_instr, if_pc, input if_ready);
    modport slave  (input if_valid, if_instr, if_pc, output if_ready);
endinterface

// File: rtl/ifetch_unit.sv
// ifetch_unit: PC register fetching from a combinational ROM into a prefetch FIFO feeding decode.
// Define FETCH_PERF_EN to add saturating pop and stall counters.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [31:0]   imem_addr,
    input  logic [31:0]   imem_rdata,
    input  logic          redirect_valid,
    input  logic [31:0]   redirect_pc,
    ifetch_unit_if.master dec
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]   perf_fetch_cnt,
    output logic [31:0]   perf_stall_cnt
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

    logic [31:0]   pc;
    logic [31:0]   mem_pc    [FIFO_DEPTH];
    logic [31:0]   mem_instr [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          pop, push;

    assign imem_addr    = pc;
    assign dec.if_valid = (count != '0) & ~redirect_valid;
    assign dec.if_instr = mem_instr[rd_ptr];
    assign dec.if_pc    = mem_pc[rd_ptr];
    assign pop          = dec.if_valid & dec.if_ready;
    // a pop frees a slot in the same cycle, so a full FIFO still streams
    assign push         = ~redirect_valid & ((count < FULL) | pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc     <= RESET_PC;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_pc[i]    <= '0;
                mem_instr[i] <= '0;
            end
        end else if (redirect_valid) begin
            pc     <= {redirect_pc[31:2], 2'b00};
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem_pc[wr_ptr]    <= pc;
                mem_instr[wr_ptr] <= imem_rdata;
                wr_ptr            <= wr_ptr + 1'b1;
                pc                <= pc + 32'd4;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (pop && perf_fetch_cnt != '1)
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (dec.if_valid && !dec.if_ready && perf_stall_cnt != '1)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: randomized scoreboard bench; expected delivery is the sequential PC stream restarted at each redirect.
module tb_ifetch_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, redirect_valid;
    logic [31:0] redirect_pc, imem_addr, imem_rdata, w_addr, w_rdata;
    ifetch_unit_if ifc();
    ifetch_unit_if wfc();
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt, perf_stall_cnt, w_fetch_cnt, w_stall_cnt;
`endif

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    function automatic logic [31:0] rom(input logic [31:0] a);
        case (a)
            32'h00:  return 32'h10013537;
            32'h04:  return 32'h00452583;
            32'h08:  return 32'h00b50023;
            32'h0C:  return 32'hfe058ee3;
            32'h20:  return 32'hff1ff06f;
            default: return 32'h00000013;
        endcase
    endfunction

    assign imem_rdata   = rom(imem_addr);
    assign w_rdata      = rom(w_addr);
    assign wfc.if_ready = 1'b1;

    ifetch_unit dut (
        .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .dec(ifc)
`ifdef FETCH_PERF_EN
        , .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    ifetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .imem_addr(w_addr), .imem_rdata(w_rdata),
        .redirect_valid(1'b0), .redirect_pc(32'h0), .dec(wfc)
`ifdef FETCH_PERF_EN
        , .perf_fetch_cnt(w_fetch_cnt), .perf_stall_cnt(w_stall_cnt)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void refill();
        while (exp_q.size() < 16) exp_q.push_back(exp_q[$] + 32'd4);
    endfunction

    function automatic void seq_from(input logic [31:0] start);
        exp_q.delete();
        exp_q.push_back({start[31:2], 2'b00});
        refill();
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (redirect_valid)
                chk("redirect_blocks_valid", 32'(ifc.if_valid), 32'd0);
            if (ifc.if_valid && ifc.if_ready) begin
                chk("sb_pc", ifc.if_pc, exp_q[0]);
                chk("sb_instr", ifc.if_instr, rom(exp_q[0]));
                void'(exp_q.pop_front());
                refill();
            end
        end
    end

    task automatic hard_reset(input logic rdy);
        @(posedge clk); #1;
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        ifc.if_ready = rdy;
        seq_from(32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        ifc.if_ready = 1'b1;
        seq_from(32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(ifc.if_valid), 32'd0);
        chk("rst_pc", ifc.if_pc, 32'h0);
        chk("rst_instr", ifc.if_instr, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_wrap_addr", w_addr, 32'hFFFF_FFF8);
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_cycle_empty", 32'(ifc.if_valid), 32'd0);
        chk("wrap_first_empty", 32'(wfc.if_valid), 32'd0);
        @(negedge clk);
        chk("first_valid", 32'(ifc.if_valid), 32'd1);
        chk("first_pc", ifc.if_pc, 32'h0);
        chk("first_instr", ifc.if_instr, 32'h10013537);
        chk("wrap_pc0", wfc.if_pc, 32'hFFFF_FFF8);
        @(negedge clk);
        chk("second_pc", ifc.if_pc, 32'h4);
        chk("second_instr", ifc.if_instr, 32'h00452583);
        chk("wrap_pc1", wfc.if_pc, 32'hFFFF_FFFC);
        @(negedge clk);
        chk("third_valid", 32'(ifc.if_valid), 32'd1);
        chk("wrap_pc2", wfc.if_pc, 32'h0);
        chk("wrap_valid2", 32'(wfc.if_valid), 32'd1);

        // decode stalls: fetch fills both entries, then holds
        hard_reset(1'b0);
        repeat (5) @(negedge clk);
        chk("stall_addr", imem_addr, 32'h8);
        chk("stall_valid", 32'(ifc.if_valid), 32'd1);
        chk("stall_head_pc", ifc.if_pc, 32'h0);
        chk("stall_head_instr", ifc.if_instr, 32'h10013537);
        @(posedge clk); #1;
        ifc.if_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("drain_valid", 32'(ifc.if_valid), 32'd1);
            chk("drain_pc", ifc.if_pc, 32'(i * 4));
        end

        // redirect with a full FIFO holding 0x0 and 0x4
        hard_reset(1'b0);
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        ifc.if_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0C;
        seq_from(32'h0C);
        @(negedge clk);
        chk("redir_cycle_valid", 32'(ifc.if_valid), 32'd0);
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("redir_gap_valid", 32'(ifc.if_valid), 32'd0);
        @(negedge clk);
        chk("redir_valid", 32'(ifc.if_valid), 32'd1);
        chk("redir_pc", ifc.if_pc, 32'h0C);
        chk("redir_instr", ifc.if_instr, 32'hfe058ee3);

        // misaligned target is forced to a word boundary
        @(posedge clk); #1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h23;
        seq_from(32'h20);
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mis_pc", ifc.if_pc, 32'h20);
        chk("mis_instr", ifc.if_instr, 32'hff1ff06f);
        @(negedge clk);
        chk("nop_pc", ifc.if_pc, 32'h24);
        chk("nop_instr", ifc.if_instr, 32'h00000013);

        // asynchronous reset in the middle of a cycle
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(ifc.if_valid), 32'd0);
        chk("midrst_addr", imem_addr, 32'h0);
        chk("midrst_pc", ifc.if_pc, 32'h0);
        chk("midrst_instr", ifc.if_instr, 32'h0);
        seq_from(32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

`ifdef FETCH_PERF_EN
        hard_reset(1'b0);
        @(negedge clk);
        chk("perf_fetch_rst", perf_fetch_cnt, 32'd0);
        chk("perf_stall_rst", perf_stall_cnt, 32'd0);
        repeat (5) @(posedge clk);
        #1;
        ifc.if_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        ifc.if_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h10;
        seq_from(32'h10);
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("perf_fetch", perf_fetch_cnt, 32'd3);
        chk("perf_stall", perf_stall_cnt, 32'd4);
        @(posedge clk); #1;
        ifc.if_ready = 1'b1;
`endif

        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            ifc.if_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 19) == 0) begin
                redirect_valid = 1'b1;
                redirect_pc = $urandom_range(0, 63);
                seq_from(redirect_pc);
            end else begin
                redirect_valid = 1'b0;
            end
        end
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        ifc.if_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("final_valid", 32'(ifc.if_valid), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
Instruction fetch stage sitting directly downstream of the combinational instruction ROM and upstream of decode. Holds the PC and drives the ROM word address. Captures each returned instruction word with its PC into a small prefetch FIFO and presents the FIFO head to decode over a valid/ready handshake. Supports PC redirect (jump/branch) with flush.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.
- FIFO_DEPTH, 2, prefetch entries; power of two, >= 2.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_addr  out  32  fetch address to ROM; equals the PC register.
- imem_rdata  in  32  instruction word from ROM, valid in the same cycle as imem_addr (combinational ROM).
- redirect_valid  in  1  pulse: load new PC and flush.
- redirect_pc  in  32  redirect target; bits [1:0] ignored (forced 0).
- if_valid  out  1  FIFO head valid to decode.
- if_instr  out  32  head instruction word.
- if_pc  out  32  PC of head instruction.
- if_ready  in  1  decode accepts head this cycle.

Behaviour:
- Reset (async assert, sync-safe release): pc = RESET_PC, FIFO empty, count = 0, so if_valid = 0; if_instr and if_pc = 0.
- imem_addr = pc (register output, no combinational path from inputs).
- pop = if_valid & if_ready & ~redirect_valid.
- push = ~redirect_valid & (count - pop < FIFO_DEPTH). When full, a same-cycle pop permits a push.
- On push: write {pc, imem_rdata} at the tail and set pc <= pc + 4.
- PC increment wraps mod 2^32: 0xFFFF_FFFC -> 0x0000_0000.
- Fetch-to-decode latency is 1 cycle: a word fetched in cycle N is at the head with if_valid = 1 in N+1 if the FIFO was empty.
- Throughput: 1 instr/cycle while if_ready = 1.
- While not full and decode stalls, fetch continues until the FIFO is full. When full and no pop, the pc holds and no push occurs.
- Redirect (redirect_valid = 1), which has priority over all other activity:
  - if_valid is forced 0 combinationally that cycle, so no handshake completes.
  - Next edge: FIFO flushed (count = 0, pointers reset), pc <= {redirect_pc[31:2], 2'b00}, no push.
  - First post-redirect instruction appears at the head 2 cycles after the redirect cycle.
- Back-to-back redirects: the last one wins; each flushes.
- Handshake: while if_valid = 1 and if_ready = 0, if_instr and if_pc stay stable until popped or flushed.
- Reset asserted mid-operation: immediate return to reset state, with no partial entries retained.

Optional Feature:
FETCH_PERF_EN
- Defined:
  - Adds outputs perf_fetch_cnt [31:0], which counts pops.
  - Adds perf_stall_cnt [31:0], which counts cycles with if_valid = 1 and if_ready = 0.
  - Both reset to 0, saturate at 0xFFFF_FFFF and are unaffected by redirect.
- Undefined: the ports and counters are absent and there is no added logic.

Test Plan:
- Reset release with RESET_PC = 0, if_ready = 1, ROM program loaded:
  - if_valid first rises 1 cycle after release, with if_pc = 0x0, if_instr = 0x10013537.
  - Next cycle: if_pc = 0x4, if_instr = 0x00452583.
  - Thereafter one instruction per cycle.
- Hold if_ready = 0 for 5 cycles after reset:
  - FIFO fills to 2; imem_addr holds at 0x8; head stays 0x0 / 0x10013537.
  - Releasing if_ready delivers pc 0x0, 0x4, 0x8 in order with no gap or duplicate.
- Redirect to 0x0C while the FIFO holds 0x0 and 0x4:
  - if_valid = 0 in the redirect cycle; no stale 0x0 or 0x4 delivered afterward.
  - Next delivered: if_pc = 0x0C, if_instr = 0xfe058ee3.
- Redirect to 0x23 (misaligned) -> fetch from 0x20, if_instr = 0xff1ff06f. Fetch at 0x24 returns the default nop 0x00000013.
- RESET_PC = 0xFFFF_FFF8, if_ready = 1 -> delivered PCs are 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000 (wrap).
- With FETCH_PERF_EN: 3 accepted instructions plus 4 stalled-valid cycles -> perf_fetch_cnt = 3, perf_stall_cnt = 4. A redirect leaves both unchanged.
